// File: rtl/hermitian_frame_sequencer_pkg.sv
// Shared types and codes for the Hermitian frame sequencer.
// Holds the Sorter load_sel codes, the FSM state encoding and the default half length.
package hermitian_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_EMIT_DC   = 3'd2,
    ST_EMIT_DATA = 3'd3,
    ST_EMIT_NYQ  = 3'd4,
    ST_EMIT_CONJ = 3'd5,
    ST_GAP       = 3'd6
  } state_t;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_DATA = 2'b01;
  localparam logic [1:0] SEL_CONJ = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  localparam int DEFAULT_HALF_LEN = 7;

endpackage

// File: rtl/hermitian_frame_sequencer.sv
// Sequences Sorter loads and Hermitian frame emission (DC, data, Nyquist, conj data).
// First bin 1 cycle after the last load accept; bins advance only on out_valid & out_ready.
module hermitian_frame_sequencer
  import hermitian_frame_sequencer_pkg::*;
#(
  parameter int HALF_LEN   = DEFAULT_HALF_LEN,
  parameter int IDX_W      = 3,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_load_en,
  input  logic             out_ready,
  output logic [1:0]       load_sel,
  output logic [IDX_W-1:0] rd_idx,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [7:0]       frame_cnt,
  output logic             busy
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HALF_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // cnt_q counts accepted samples in LOAD and doubles as the bin tap index while emitting.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (cnt_q == IDX_LAST) begin
            state_d = ST_EMIT_DC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_EMIT_DC: begin
        if (out_ready) begin
          state_d = ST_EMIT_DATA;
          cnt_d   = '0;
        end
      end
      ST_EMIT_DATA: begin
        if (out_ready) begin
          if (cnt_q == IDX_LAST) state_d = ST_EMIT_NYQ;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_EMIT_NYQ: begin
        if (out_ready) begin
          state_d = ST_EMIT_CONJ;
          cnt_d   = IDX_LAST;
        end
      end
      ST_EMIT_CONJ: begin
        if (out_ready) begin
          if (cnt_q == '0) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            gap_cnt_d   = '0;
            if (GAP_CYCLES == 0) state_d = enable ? ST_LOAD : ST_IDLE;
            else                 state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = enable ? ST_LOAD : ST_IDLE;
          cnt_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    load_sel  = SEL_HOLD;
    rd_idx    = '0;
    case (state_q)
      ST_EMIT_DC: begin
        out_valid = 1'b1;
        out_sop   = 1'b1;
        load_sel  = SEL_ZERO;
      end
      ST_EMIT_DATA: begin
        out_valid = 1'b1;
        load_sel  = SEL_DATA;
        rd_idx    = cnt_q;
      end
      ST_EMIT_NYQ: begin
        out_valid = 1'b1;
        load_sel  = SEL_ZERO;
      end
      ST_EMIT_CONJ: begin
        out_valid = 1'b1;
        load_sel  = SEL_CONJ;
        rd_idx    = cnt_q;
        out_eop   = (cnt_q == '0);
      end
      default: ;
    endcase
  end

  assign shift_load_en = in_valid & in_ready;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hermitian_frame_sequencer.sv
// Directed bench for hermitian_frame_sequencer with M=7, GAP=2 (16-bin frames).
module tb_hermitian_frame_sequencer;

  logic       clk = 1'b0;
  logic       reset, enable, in_valid, out_ready;
  logic       in_ready, shift_load_en, out_valid, out_sop, out_eop, busy;
  logic [1:0] load_sel;
  logic [2:0] rd_idx;
  logic [7:0] frame_cnt;

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  hermitian_frame_sequencer #(.HALF_LEN(7), .IDX_W(3), .GAP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_ready(in_ready), .shift_load_en(shift_load_en), .out_ready(out_ready),
    .load_sel(load_sel), .rd_idx(rd_idx), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .frame_cnt(frame_cnt), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Registered outputs settle 1 time unit after the edge; inputs change there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_shift"}, shift_load_en, 0);
    chk({tag, "_sop"}, out_sop, 0);
    chk({tag, "_eop"}, out_eop, 0);
    chk({tag, "_rd_idx"}, rd_idx, 0);
    chk({tag, "_sel"}, load_sel, 2'b11);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Starts in LOAD; ends on the first emit cycle.
  task automatic load_frame(input bit bubbly);
    int pulses = 0;
    for (int i = 0; i < 40 && pulses < 7; i++) begin
      in_valid = bubbly ? ((i % 2) == 0) : 1'b1;
      #1;
      chk("load_in_ready", in_ready, 1);
      chk("load_shift", shift_load_en, in_valid);
      if (shift_load_en) pulses++;
      cyc();
    end
    chk("load_accepts", pulses, 7);
    in_valid = 1'b1;
    #1;
    chk("first_bin_valid", out_valid, 1);
    chk("first_bin_sop", out_sop, 1);
    chk("emit_no_shift", shift_load_en, 0);
  endtask

  // Bin k of the frame: DC, data[0..6], Nyquist, conj data[6..0].
  task automatic chk_bin(input int k);
    logic [1:0] es;
    logic [2:0] ei;
    es = (k == 0 || k == 8) ? 2'b00 : (k < 8) ? 2'b01 : 2'b10;
    ei = (k >= 1 && k <= 7) ? 3'(k - 1) : (k >= 9) ? 3'(15 - k) : 3'd0;
    chk("bin_valid", out_valid, 1);
    chk("bin_sel", load_sel, es);
    chk("bin_idx", rd_idx, ei);
    chk("bin_sop", out_sop, k == 0);
    chk("bin_eop", out_eop, k == 15);
  endtask

  task automatic emit_frame(input int stall_bin, input int stall_len,
                            input int drop_bin, input int stop_bin);
    int k = 0;
    int stalled = 0;
    for (int n = 0; n < 100 && k < 16 && k != stop_bin; n++) begin
      chk_bin(k);
      if (k == stall_bin && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      if (k == drop_bin) enable = 1'b0;
      if (out_ready) k++;
      cyc();
    end
    out_ready = 1'b1;
    chk("emit_bins", k, (stop_bin < 16) ? stop_bin : 16);
  endtask

  task automatic gap_then(input bit expect_load);
    for (int g = 0; g < 2; g++) begin
      chk("gap_valid", out_valid, 0);
      chk("gap_in_ready", in_ready, 0);
      chk("gap_sel", load_sel, 2'b11);
      chk("gap_busy", busy, 1);
      cyc();
    end
    chk("after_gap_in_ready", in_ready, expect_load);
    chk("after_gap_busy", busy, expect_load);
  endtask

  initial begin
    int eops;
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      enable = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    in_valid = 1'b1;
    #1;
    chk_reset_state("reset");

    // Nominal frame
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1;
    cyc();
    load_frame(1'b0);
    emit_frame(99, 0, 99, 99);
    chk("nominal_frame_cnt", frame_cnt, 1);
    gap_then(1'b1);

    // Backpressure on bin 4
    load_frame(1'b0);
    emit_frame(4, 5, 99, 99);
    chk("bp_frame_cnt", frame_cnt, 2);
    gap_then(1'b1);

    // Bubbly input
    load_frame(1'b1);
    emit_frame(99, 0, 99, 99);
    chk("bubbly_frame_cnt", frame_cnt, 3);
    gap_then(1'b1);

    // enable dropped on bin 3
    load_frame(1'b0);
    emit_frame(99, 0, 3, 99);
    chk("drop_frame_cnt", frame_cnt, 4);
    gap_then(1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("idle_in_ready", in_ready, 0);
      chk("idle_shift", shift_load_en, 0);
      chk("idle_busy", busy, 0);
    end

    // Reset on bin 9, then clean frame
    enable = 1'b1;
    cyc();
    load_frame(1'b0);
    emit_frame(99, 0, 99, 9);
    reset = 1'b1;
    cyc();
    chk_reset_state("midreset");
    reset = 1'b0;
    cyc();
    load_frame(1'b0);
    emit_frame(99, 0, 99, 99);
    chk("post_reset_frame_cnt", frame_cnt, 1);
    gap_then(1'b1);

    // 255 more frames: counter reaches 255 then wraps to 0
    eops = 0;
    in_valid = 1'b1; out_ready = 1'b1; enable = 1'b1;
    for (int n = 0; n < 20000 && eops < 255; n++) begin
      if (out_valid && out_eop) begin
        eops++;
        if (eops == 255) chk("frame_cnt_255", frame_cnt, 255);
      end
      cyc();
    end
    chk("wrap_eops", eops, 255);
    chk("frame_cnt_wrap", frame_cnt, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
